// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - LSB-first serial pattern source; loop mode under `PATTERN_GEN_REPEAT_EN
module serial_pattern_gen #(
    parameter int   WIDTH      = 16,
    parameter int   CNTW       = 5,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNTW-1:0]  len,
`ifdef PATTERN_GEN_REPEAT_EN
    input  logic             rpt,
`endif
    output logic             I,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  bit_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [CNTW-1:0]   len_q;
    logic [CNTW-1:0]   len_clamped;
    logic              last_bit;
`ifdef PATTERN_GEN_REPEAT_EN
    logic [WIDTH-1:0]  pat_q;
`endif

    // Oversized requests are trimmed to the shift register size
    always_comb begin
        len_clamped = (len > WIDTH_C) ? WIDTH_C : len;
    end

    // The bit on I is the final one of this pass
    always_comb begin
        last_bit = (bit_idx == (len_q - ONE_C));
    end

    // Control FSM with registered outputs; the shift register's bit 0 is always the bit on I
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            len_q   <= '0;
            I       <= IDLE_LEVEL;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
`ifdef PATTERN_GEN_REPEAT_EN
            pat_q   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    I       <= IDLE_LEVEL;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    bit_idx <= '0;
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            shreg   <= pattern;
                            len_q   <= len_clamped;
`ifdef PATTERN_GEN_REPEAT_EN
                            pat_q   <= pattern;
`endif
                            I       <= pattern[0];
                            valid   <= 1'b1;
                            state   <= S_SEND;
                        end else begin
                            // Empty request: skip straight to the completion handshake
                            len_q   <= '0;
                            state   <= S_DONE;
                        end
                    end
                end

                S_SEND: begin
                    if (!last_bit) begin
                        shreg   <= shreg >> 1;
                        I       <= shreg[1];
                        bit_idx <= bit_idx + ONE_C;
`ifdef PATTERN_GEN_REPEAT_EN
                    end else if (rpt) begin
                        // Loop back to bit 0 with no idle gap and no done pulse
                        shreg   <= pat_q;
                        I       <= pat_q[0];
                        bit_idx <= '0;
`endif
                    end else begin
                        I       <= IDLE_LEVEL;
                        valid   <= 1'b0;
                        bit_idx <= '0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!done) begin
                        // Arrived from a zero-length request: raise done one cycle late
                        done  <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    shreg   <= '0;
                    len_q   <= '0;
                    I       <= IDLE_LEVEL;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - bench for serial_pattern_gen
module tb_serial_pattern_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
`ifdef PATTERN_GEN_REPEAT_EN
    logic        rpt;
`endif
    logic        ser;
    logic        valid;
    logic        busy;
    logic        done;
    logic [4:0]  bit_idx;

    int errors = 0;
    int checks = 0;

    serial_pattern_gen #(.WIDTH(16), .CNTW(5), .IDLE_LEVEL(1'b0)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
`ifdef PATTERN_GEN_REPEAT_EN
        .rpt     (rpt),
`endif
        .I       (ser),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    always #5 clock = ~clock;

    // Expected output timeline: q[0] is what the current cycle should show; empty means idle
    typedef struct {
        logic       i;
        logic       v;
        logic       b;
        logic       d;
        logic [4:0] idx;
        bit         last;
    } rec_t;

    rec_t        q[$];
    logic [15:0] m_pat;
    int          m_n;

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  ln;
        logic [15:0] exp_bits;
        int          n;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic i, input logic v, input logic b, input logic d,
                                input int idx, input bit last);
        rec_t r;
        r.i = i; r.v = v; r.b = b; r.d = d; r.idx = 5'(idx); r.last = last;
        return r;
    endfunction

    task automatic push_pass_front();
        for (int k = m_n - 1; k >= 0; k--)
            q.push_front(mk(m_pat[k], 1'b1, 1'b1, 1'b0, k, (k == m_n - 1)));
    endtask

    // Advance the reference by one clock edge using the inputs present at that edge
    task automatic model_edge();
        rec_t r;
        if (q.size() == 0) begin
            if (start) begin
                m_pat = pattern;
                m_n   = (int'(len) > 16) ? 16 : int'(len);
                if (m_n == 0) begin
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0));
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0));
                end else begin
                    for (int k = 0; k < m_n; k++)
                        q.push_back(mk(m_pat[k], 1'b1, 1'b1, 1'b0, k, (k == m_n - 1)));
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0));
                end
            end
        end else begin
            r = q.pop_front();
`ifdef PATTERN_GEN_REPEAT_EN
            if (r.last && rpt) push_pass_front();
`endif
        end
    endtask

    task automatic compare_model();
        logic [8:0] exp;
        if (q.size() == 0) exp = 9'b0;
        else exp = {q[0].i, q[0].v, q[0].b, q[0].d, q[0].idx};
        chk("model", {23'b0, ser, valid, busy, done, bit_idx}, {23'b0, exp});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_model();
    endtask

    task automatic drain();
        start = 1'b0;
`ifdef PATTERN_GEN_REPEAT_EN
        rpt = 1'b0;
`endif
        for (int t = 0; t < 60 && q.size() != 0; t++) step();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy=%0d expected idle within 60 cycles", busy);
        end
    endtask

    task automatic run_vec(input logic [15:0] pat, input logic [4:0] ln,
                           input logic [15:0] eb, input int n);
        drain();
        pattern = pat;
        len     = ln;
        start   = 1'b1;
        step();
        start   = 1'b0;
        if (n == 0) begin
            chk("len0_c1", {28'b0, ser, valid, busy, done}, 32'b0010);
            step();
            chk("len0_c2", {28'b0, ser, valid, busy, done}, 32'b0011);
            step();
            chk("len0_c3", {28'b0, ser, valid, busy, done}, 32'b0000);
        end else begin
            for (int b = 0; b < n; b++) begin
                chk("vec_bit", {23'b0, ser, valid, busy, done, bit_idx},
                    {23'b0, eb[b], 1'b1, 1'b1, 1'b0, 5'(b)});
                pattern = 16'($urandom);
                len     = 5'($urandom);
                start   = 1'($urandom_range(0, 1));
                step();
            end
            start = 1'b0;
            chk("vec_done", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0_0_1_1_00000);
            step();
            chk("vec_idle", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0);
        end
    endtask

    initial begin
        vecs[0] = '{16'h0035, 5'd6,  16'h0035, 6};
        vecs[1] = '{16'hA5F0, 5'd20, 16'hA5F0, 16};
        vecs[2] = '{16'hFFFF, 5'd1,  16'h0001, 1};
        vecs[3] = '{16'h1234, 5'd0,  16'h0000, 0};
        vecs[4] = '{16'h8001, 5'd16, 16'h8001, 16};
        vecs[5] = '{16'h4C2B, 5'd31, 16'h4C2B, 16};

        start   = 1'b0;
        pattern = '0;
        len     = '0;
`ifdef PATTERN_GEN_REPEAT_EN
        rpt     = 1'b0;
`endif
        reset   = 1'b1;
        #2 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_hold", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("post_reset_idle", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0);
        end

        foreach (vecs[v]) run_vec(vecs[v].pat, vecs[v].ln, vecs[v].exp_bits, vecs[v].n);

        // Reset asserted while bit 3 is on the line aborts without a done pulse
        drain();
        pattern = 16'hFFFF;
        len     = 5'd10;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        step();
        step();
        chk("abort_at_bit3", {27'b0, bit_idx}, 32'd3);
        #2 reset = 1'b0;
        #1 chk("abort_async", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0);
        q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("abort_no_done", {31'b0, done}, 32'b0);
        end

`ifdef PATTERN_GEN_REPEAT_EN
        begin
            logic [8:0] exp9;
            exp9 = 9'b101101101;
            drain();
            pattern = 16'h0005;
            len     = 5'd3;
            rpt     = 1'b1;
            start   = 1'b1;
            step();
            start   = 1'b0;
            for (int b = 0; b < 9; b++) begin
                chk("rpt_bit", {23'b0, ser, valid, busy, done, bit_idx},
                    {23'b0, exp9[b], 1'b1, 1'b1, 1'b0, 5'(b % 3)});
                rpt = (b < 6);
                step();
            end
            rpt = 1'b0;
            chk("rpt_done", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0_0_1_1_00000);
            step();
            chk("rpt_idle", {23'b0, ser, valid, busy, done, bit_idx}, 32'b0);
        end
`endif

        // Random traffic against the timeline model
        for (int c = 0; c < 400; c++) begin
            start   = ($urandom_range(0, 2) == 0);
            pattern = 16'($urandom);
            len     = 5'($urandom_range(0, 20));
`ifdef PATTERN_GEN_REPEAT_EN
            rpt     = ($urandom_range(0, 3) == 0);
`endif
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Serial stimulus source for the lab's Moore sequence detectors: it is the transmitting end of the single-bit `I` interface those detectors receive.
- Latches a parallel pattern and a length, then drives the pattern onto `I` one bit per clock, LSB first.
- Provides valid/busy/done status so a top level or bench can chain patterns back-to-back without hand-written delay sequences.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- CNTW, 5, width of length/index fields; must be at least clog2(WIDTH)+1.
- IDLE_LEVEL, 0, value driven on I whenever valid is low.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- pattern  in  WIDTH  bits to send; bit 0 is sent first.
- len  in  CNTW  number of bits to send; values above WIDTH are clamped to WIDTH.
- I  out  1  serial data bit.
- valid  out  1  high while I carries a pattern bit.
- busy  out  1  high in SEND and DONE.
- done  out  1  one-cycle pulse after the last bit.
- bit_idx  out  CNTW  index of the bit currently on I; 0 when not valid.

Behaviour:
- Reset (reset=0, async, overrides everything):
  - state=IDLE; I=IDLE_LEVEL; valid=0, busy=0, done=0, bit_idx=0.
  - Shift register and latched length cleared.
  - Reset mid-transfer aborts immediately. No done pulse. After release, the block waits for a new start.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE=2'b00, SEND=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and returns to IDLE on the next edge with outputs at reset values.
- IDLE:
  - On an edge with start=1 and len!=0: latch pattern into the shift register and min(len,WIDTH) into the length register; go to SEND.
  - On that same edge: I<=pattern[0], valid<=1, busy<=1, bit_idx<=0.
  - On an edge with start=1 and len==0: no transmission; go to DONE (busy=1, valid=0). done pulses one cycle later.
- SEND:
  - Each edge: if bit_idx != latched_len-1, shift right, I<=next bit, bit_idx<=bit_idx+1.
  - If bit_idx == latched_len-1: I<=IDLE_LEVEL, valid<=0, bit_idx<=0, done<=1, go to DONE.
- DONE:
  - Lasts exactly one cycle with done=1, busy=1.
  - Next edge: done<=0, busy<=0, go to IDLE.
- Latency: a start sampled at edge k puts bit i on I during the cycle after edge k+i. done is high during the cycle after edge k+len.
  - Minimum start-to-start spacing is len+2 cycles.
- start while busy=1 is ignored; no queuing.
- pattern and len may change freely once latched; later changes do not affect an ongoing transfer.
- len=WIDTH sends every bit. bit_idx counts up to WIDTH-1 and never wraps within a pass.

Optional Feature:
- Macro: PATTERN_GEN_REPEAT_EN
- Defined:
  - Adds input port rpt (1 bit).
  - At the edge ending the final bit, if rpt=1: reload the latched pattern, I<=bit 0, bit_idx<=0, valid stays 1, stay in SEND. No gap and no done pulse.
  - If rpt=0 at that edge: normal termination through DONE.
  - Reset still aborts looping.
- Undefined: rpt port absent; single pass only, exactly as in Behaviour.

Test Plan:
- Reset hold then release, no start for 5 cycles -> I=0, valid=0, busy=0, done=0, bit_idx=0 throughout.
- pattern=16'h0035, len=6, start pulse at edge k -> I = 1,0,1,0,1,1 in cycles k+1..k+6; bit_idx 0..5; valid high exactly 6 cycles; done high only in cycle k+7; busy low from cycle k+8.
- len=0 with start -> valid never rises; done pulses once, 2 cycles after start; busy high 2 cycles.
- len=20 (above WIDTH), pattern=16'hA5F0 -> exactly 16 bits sent, LSB first: 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1; done after the 16th bit.
- Start re-asserted during SEND, and pattern changed mid-transfer -> ignored, sent bits unchanged. reset=0 at bit 3 -> I, valid and busy drop asynchronously; no done pulse.
- PATTERN_GEN_REPEAT_EN defined, pattern=16'h0005, len=3, rpt=1 for 2 passes then 0 -> I = 1,0,1,1,0,1,1,0,1 contiguous, valid continuous; single done pulse after the 9th bit.
